// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable slow-clock and tick generator
module clk_divider_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 50,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [N_CH-1:0]   cfg_pending,
    output logic [N_CH-1:0]   slowclk,
    output logic [N_CH-1:0]   tick
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt        [N_CH];
    logic [CNT_W-1:0] active_div [N_CH];
    logic [CNT_W-1:0] shadow     [N_CH];

    logic [N_CH-1:0] wr_hit;
    logic [N_CH-1:0] run;
    logic [N_CH-1:0] tc;

    // Per-channel write decode, run qualifier and terminal-count detect.
    // An out-of-range cfg_ch matches no channel, so such writes fall away.
    // The active_div-1 compare is gated by run so a zero divisor never wraps.
    always_comb begin
        wr_hit = '0;
        run    = '0;
        tc     = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            run[i]    = en[i] && (active_div[i] != '0);
            tc[i]     = run[i] && (cnt[i] == (active_div[i] - CNT_W'(1)));
        end
    end

    // Channel state: counters, divisor shadowing, square clock and rising-edge tick.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]        <= '0;
                active_div[i] <= DEF;
                shadow[i]     <= DEF;
            end
            cfg_pending <= '0;
            slowclk     <= '1;
            tick        <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_clr) begin
                    // Realign: every channel restarts high, pending divisors land now,
                    // and a same-cycle write bypasses the shadow entirely.
                    cnt[i]         <= '0;
                    slowclk[i]     <= 1'b1;
                    tick[i]        <= 1'b0;
                    cfg_pending[i] <= 1'b0;
                    if (wr_hit[i]) begin
                        active_div[i] <= cfg_div;
                        shadow[i]     <= cfg_div;
                    end else if (cfg_pending[i]) begin
                        active_div[i] <= shadow[i];
                    end
                end else begin
                    tick[i] <= 1'b0;
                    if (run[i]) begin
                        if (tc[i]) begin
                            cnt[i]     <= '0;
                            slowclk[i] <= ~slowclk[i];
                            tick[i]    <= ~slowclk[i];
                            // Divisor changes only at a half-period boundary: no runt pulses.
                            if (cfg_pending[i]) begin
                                active_div[i]  <= shadow[i];
                                cfg_pending[i] <= 1'b0;
                            end
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end else if (cfg_pending[i]) begin
                        // Idle channel has no phase to protect, so apply at once.
                        active_div[i]  <= shadow[i];
                        cfg_pending[i] <= 1'b0;
                        cnt[i]         <= '0;
                    end
                    // A write in the apply cycle wins: the old shadow was used above,
                    // the new value stays pending for the next boundary.
                    if (wr_hit[i]) begin
                        shadow[i]      <= cfg_div;
                        cfg_pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - directed self-checking bench for clk_divider_multi
module tb_clk_divider_multi;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync_clr;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_pending;
    logic [3:0]  slowclk;
    logic [3:0]  tick;

    logic [2:0]  en2;
    logic        sync_clr2;
    logic        cfg_we2;
    logic [1:0]  cfg_ch2;
    logic [15:0] cfg_div2;
    logic [2:0]  cfg_pending2;
    logic [2:0]  slowclk2;
    logic [2:0]  tick2;

    int checks = 0;
    int errors = 0;

    clk_divider_multi dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_pending (cfg_pending),
        .slowclk     (slowclk),
        .tick        (tick)
    );

    clk_divider_multi #(.N_CH(3), .DEF_DIV(4)) dut3 (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .en          (en2),
        .sync_clr    (sync_clr2),
        .cfg_we      (cfg_we2),
        .cfg_ch      (cfg_ch2),
        .cfg_div     (cfg_div2),
        .cfg_pending (cfg_pending2),
        .slowclk     (slowclk2),
        .tick        (tick2)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wait_lvl(input string tag, input int ch, input logic lvl,
                            input int bound, output int n);
        n = 0;
        while (slowclk[ch] !== lvl && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_reached"}, 32'(slowclk[ch]), 32'(lvl));
    endtask

    initial begin
        int n;
        int tcount;
        int first [4];
        logic lvl;
        logic changed;
        logic seen_tick;

        rst_n = 1'b0; en = '0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        en2 = '0; sync_clr2 = 1'b0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_div2 = '0;
        step(3);
        check("rst_slowclk", 32'(slowclk), 32'hf);
        check("rst_tick",    32'(tick),    32'h0);
        check("rst_pending", 32'(cfg_pending), 32'h0);

        // Defaults on channel 0.
        rst_n = 1'b1; en = 4'b0001;
        wait_lvl("ch0_fall", 0, 1'b0, 200, n);
        check("ch0_first_fall", n, 50);
        wait_lvl("ch0_rise", 0, 1'b1, 200, n);
        check("ch0_rise_half", n, 50);
        check("ch0_tick_at_rise", 32'(tick[0]), 1);
        tcount = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (tick[0]) tcount++;
        end
        check("ch0_ticks_per_100", tcount, 1);
        check("ch123_hold", 32'(slowclk[3:1]), 32'h7);

        // Channel 1: write divisor 3 mid-count.
        en[1] = 1'b1;
        step(20);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
        step(1);
        cfg_we = 1'b0;
        check("ch1_pending_set", 32'(cfg_pending[1]), 1);
        wait_lvl("ch1_fall", 1, 1'b0, 100, n);
        check("ch1_old_half_end", n, 29);
        check("ch1_pending_clr", 32'(cfg_pending[1]), 0);
        wait_lvl("ch1_rise", 1, 1'b1, 100, n);
        check("ch1_new_half_a", n, 3);
        check("ch1_tick", 32'(tick[1]), 1);
        wait_lvl("ch1_fall2", 1, 1'b0, 100, n);
        check("ch1_new_half_b", n, 3);

        // Channel 2: divide-by-2 of sysclk, applied while idle.
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd1;
        step(1);
        cfg_we = 1'b0;
        step(1);
        check("ch2_idle_apply", 32'(cfg_pending[2]), 0);
        en[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("ch2_clk_%0d", k),  32'(slowclk[2]), 32'((k % 2) == 0));
            check($sformatf("ch2_tick_%0d", k), 32'(tick[2]),    32'((k % 2) == 0));
        end

        // Channel 3: back-to-back writes, only the last applies.
        en[3] = 1'b1;
        step(5);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
        step(1);
        cfg_div = 16'd9;
        step(1);
        cfg_we = 1'b0;
        check("ch3_pending", 32'(cfg_pending[3]), 1);
        wait_lvl("ch3_fall", 3, 1'b0, 100, n);
        check("ch3_old_half_end", n, 43);
        check("ch3_pending_clr", 32'(cfg_pending[3]), 0);
        wait_lvl("ch3_rise", 3, 1'b1, 100, n);
        check("ch3_half_a", n, 9);
        wait_lvl("ch3_fall2", 3, 1'b0, 100, n);
        check("ch3_half_b", n, 9);

        // Channel 0: disable for 37 cycles at cnt=10 while low.
        wait_lvl("ch0_sync_hi", 0, 1'b1, 200, n);
        wait_lvl("ch0_sync_lo", 0, 1'b0, 200, n);
        step(10);
        en[0] = 1'b0;
        changed = 1'b0; seen_tick = 1'b0;
        for (int k = 0; k < 37; k++) begin
            step(1);
            if (slowclk[0] !== 1'b0) changed = 1'b1;
            if (tick[0] !== 1'b0) seen_tick = 1'b1;
        end
        check("ch0_frozen", 32'(changed), 0);
        check("ch0_no_tick_idle", 32'(seen_tick), 0);
        en[0] = 1'b1;
        wait_lvl("ch0_resume", 0, 1'b1, 200, n);
        check("ch0_resume_delay", n, 40);

        // sync_clr with a pending ch1 divisor and a same-cycle ch0 write.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4;
        step(1);
        sync_clr = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd5;
        step(1);
        sync_clr = 1'b0; cfg_we = 1'b0;
        check("clr_slowclk", 32'(slowclk), 32'hf);
        check("clr_tick", 32'(tick), 32'h0);
        check("clr_pending", 32'(cfg_pending), 32'h0);
        for (int c = 0; c < 4; c++) first[c] = 0;
        for (int t = 1; t <= 20; t++) begin
            step(1);
            for (int c = 0; c < 4; c++)
                if (first[c] == 0 && slowclk[c] == 1'b0) first[c] = t;
        end
        check("clr_fall_ch0", first[0], 5);
        check("clr_fall_ch1", first[1], 4);
        check("clr_fall_ch2", first[2], 1);
        check("clr_fall_ch3", first[3], 9);

        // Divisor 0 on running channel 3 stops it at the apply edge.
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd0;
        step(1);
        cfg_we = 1'b0;
        check("ch3_zero_pending", 32'(cfg_pending[3]), 1);
        lvl = slowclk[3];
        wait_lvl("ch3_zero_apply", 3, ~lvl, 20, n);
        check("ch3_zero_pending_clr", 32'(cfg_pending[3]), 0);
        lvl = slowclk[3];
        changed = 1'b0; seen_tick = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (slowclk[3] !== lvl) changed = 1'b1;
            if (tick[3] !== 1'b0) seen_tick = 1'b1;
        end
        check("ch3_stopped", 32'(changed), 0);
        check("ch3_stopped_tick", 32'(seen_tick), 0);

        // Asynchronous reset mid-count.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_slowclk", 32'(slowclk), 32'hf);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_pending", 32'(cfg_pending), 32'h0);
        @(posedge sysclk);
        #1;
        rst_n = 1'b1; en = 4'b0001;
        en2 = 3'b001; cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_div2 = 16'd1;
        step(1);
        cfg_we2 = 1'b0;
        check("oob_write_pending", 32'(cfg_pending2), 32'h0);
        check("oob_write_clk", 32'(slowclk2), 32'h7);
        step(3);
        check("oob_ch0_def_fall", 32'(slowclk2[0]), 0);
        wait_lvl("post_rst_fall", 0, 1'b0, 200, n);
        check("post_rst_div50", n, 46);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
